live_audio_rx: RTL and testbench
================================

# live_audio_rx

Single-clock stereo audio receiver. It is the sink-side counterpart of the audio stream transmitter: it accepts the 32-bit subframe stream (data / id / valid / ready) from an audio capture or formatter interface and extracts AUDIO_WIDTH-bit samples. It pairs left and right subframes into {left, right} words and buffers them in a small show-ahead FIFO for the sample-processing logic in the system clock domain.

## Interface
- AUDIO_WIDTH, 16: bits per channel sample; legal range 8..24.
- BUFFER_DEPTH, 4: log2 of FIFO depth, so the FIFO holds 16 stereo words.
- AES_MODE, 0: subframe format. 0 = PCM, sample in bits [31:32-AUDIO_WIDTH]. 1 = AES3, sample in bits [27:28-AUDIO_WIDTH], bits [3:0] preamble, bits [31:28] P C U V ignored.
- clk  in  1  system clock; the block has one clock.
- reset  in  1  reset; synchronous, active-high.
- data_rx  in  32  subframe word.
- id_rx  in  1  channel of subframe: 0 = left, 1 = right.
- valid_rx  in  1  subframe valid.
- ready_rx  out  1  block accepts the subframe this cycle.
- data_out  out  2*AUDIO_WIDTH  head-of-FIFO stereo word {left, right}; valid while empty=0.
- rd_en  in  1  pop the head word; ignored when empty=1.
- empty  out  1  FIFO empty.
- level  out  BUFFER_DEPTH+1  FIFO occupancy.
- sync_err  out  8  saturating count of out-of-order subframes.

## Operation
- A transfer occurs when valid_rx && ready_rx are both high at a rising edge of clk.
- Sample extraction is a combinational slice of data_rx selected by AES_MODE. The result is a signed two's-complement value and is not rescaled.
- Pairing FSM, reset state WAIT_L:
  - WAIT_L, id=0: store the sample in the left register, go to WAIT_R.
  - WAIT_L, id=1: discard the subframe, increment sync_err, stay in WAIT_L.
  - WAIT_R, id=1: write {left, sample} to the FIFO, go to WAIT_L.
  - WAIT_R, id=0: overwrite the left register, increment sync_err, stay in WAIT_R.
- ready_rx is combinational:
  - 1 in WAIT_L, because a left sample only loads a register.
  - In WAIT_R, ready_rx = ~full.
  - Backpressure therefore stalls only the right subframe. No sample pair is ever dropped because the FIFO is full.
- FIFO:
  - Synchronous, show-ahead; full when level = 2**BUFFER_DEPTH.
  - data_out = mem[rd_ptr], combinational from the registered array and pointer.
  - Pointers are BUFFER_DEPTH+1 bits and wrap modulo 2**(BUFFER_DEPTH+1). Full and empty are derived from the MSB and the lower bits.
- A simultaneous write and pop at level L leaves level unchanged. The write is always permitted, because ready_rx already guarantees L < depth.
- rd_en while empty has no effect: pointers and level are unchanged.
- sync_err saturates at 255. It is cleared only by reset.
- Reset values:
  - state = WAIT_L, left register = 0.
  - Pointers = 0, so level = 0 and empty = 1.
  - sync_err = 0.
  - ready_rx = 1 in the cycle after reset deasserts.
  - data_out is undefined while empty.
- Reset mid-pair, in WAIT_R: the held left sample is discarded. Reset while the FIFO is non-empty discards all stored words.

## Timing
- Right-subframe transfer at edge N: the word is written at edge N. empty falls, level increments, and data_out shows the word in cycle N+1. Write-to-read latency is 1 cycle.
- Pop at edge N: data_out shows the next entry, and level/empty are updated, in cycle N+1.
- Back-to-back transfers are accepted at one per cycle with no bubbles while the FIFO is not full.
- ready_rx drops in the same cycle that full and WAIT_R are both true. It rises in the cycle after a pop.
- sync_err updates at the same edge as the offending transfer.

## Structure
- Shared package holds:
  - FSM state constants WAIT_L / WAIT_R.
  - Subframe field offsets: PCM MSB 31, AES MSB 27, AES preamble [3:0].
  - Channel id constants ID_LEFT = 0, ID_RIGHT = 1.
- One sub-module, sync_fifo. Parameters: width = 2*AUDIO_WIDTH, depth = BUFFER_DEPTH. Ports: we, din, re, dout, empty, full, level.
- The top of the block contains the extraction slice, the pairing FSM, the left register and the sync_err counter.

## Test plan
- Reset then L=0x1234_0000, R=0xABCD_0000 with AES_MODE=0 -> one cycle later empty=0, data_out=0x1234ABCD, level=1, sync_err=0.
- AES_MODE=1 subframes L=0x0123_4560, R=0x0FED_CBA0 -> data_out=0x1234FEDC.
- Never pop; send 17 L/R pairs -> level=16, ready_rx=0 while the 17th right subframe is held. Pop once -> ready_rx=1 next cycle, the 17th pair is written, level=16.
- Sequence R, L, L, R (first L=1, second L=2, R=3) -> sync_err=2, single FIFO word {2,3}.
- Reset asserted in WAIT_R with level=5 -> next cycle empty=1, level=0, ready_rx=1. The following lone right subframe is discarded and sync_err=1.
- Continuous pairs with rd_en held high at rate -> level oscillates 0..1, no stalls, output order matches input order over 1000 random pairs.

Source files
------------

// File: rtl/live_audio_rx_pkg.sv
// Shared constants and helpers for the stereo subframe receiver.
package live_audio_rx_pkg;

  typedef enum logic {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } pair_state_t;

  localparam int SUBFRAME_W  = 32;
  localparam int PCM_MSB     = 31;
  localparam int AES_MSB     = 27;
  localparam int AES_PRE_MSB = 3;
  localparam int AES_PRE_LSB = 0;

  localparam logic ID_LEFT  = 1'b0;
  localparam logic ID_RIGHT = 1'b1;

  localparam logic [7:0] SYNC_ERR_MAX = 8'hFF;

  function automatic int sample_msb(input int aes_mode);
    return (aes_mode != 0) ? AES_MSB : PCM_MSB;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == SYNC_ERR_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/live_audio_rx_if.sv
// Subframe stream handshake: data / channel id / valid from the source, ready from the sink.
interface live_audio_rx_if;
  import live_audio_rx_pkg::*;

  logic [SUBFRAME_W-1:0] data_rx;
  logic                  id_rx;
  logic                  valid_rx;
  logic                  ready_rx;

  modport master (output data_rx, output id_rx, output valid_rx, input ready_rx);
  modport slave  (input data_rx, input id_rx, input valid_rx, output ready_rx);

endinterface

// File: rtl/live_audio_rx_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [DEPTH:0]   level
);

  localparam int ENTRIES = 1 << DEPTH;

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [DEPTH:0]   r_wr_ptr;
  logic [DEPTH:0]   r_rd_ptr;
  logic             w_re;

  assign w_re  = re && !empty;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[DEPTH] != r_rd_ptr[DEPTH]) &&
                 (r_wr_ptr[DEPTH-1:0] == r_rd_ptr[DEPTH-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[DEPTH-1:0]];

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_mem[r_wr_ptr[DEPTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (we)   r_wr_ptr <= r_wr_ptr + (DEPTH+1)'(1);
      if (w_re) r_rd_ptr <= r_rd_ptr + (DEPTH+1)'(1);
    end
  end

endmodule

// File: rtl/live_audio_rx.sv
// Stereo subframe receiver: extracts samples, pairs left/right and queues {left, right} words.
module live_audio_rx
  import live_audio_rx_pkg::*;
#(
  parameter int AUDIO_WIDTH  = 16,
  parameter int BUFFER_DEPTH = 4,
  parameter int AES_MODE     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  live_audio_rx_if.slave           rx,
  output logic [2*AUDIO_WIDTH-1:0] data_out,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [BUFFER_DEPTH:0]    level,
  output logic [7:0]               sync_err
);

  localparam int SAMPLE_MSB = sample_msb(AES_MODE);

  pair_state_t              r_state;
  logic [AUDIO_WIDTH-1:0]   r_left;
  logic [7:0]               r_sync_err;

  logic [AUDIO_WIDTH-1:0]   w_sample;
  logic                     w_ready;
  logic                     w_xfer;
  logic                     w_full;
  logic                     w_fifo_we;
  logic                     w_unused_bits;

  assign w_sample      = rx.data_rx[SAMPLE_MSB -: AUDIO_WIDTH];
  assign w_unused_bits = ^{rx.data_rx, rx.data_rx[AES_PRE_MSB:AES_PRE_LSB]};

  // Only the right subframe ever needs FIFO space, so backpressure applies only in WAIT_R.
  assign w_ready     = (r_state == WAIT_L) || !w_full;
  assign rx.ready_rx = w_ready;
  assign w_xfer      = rx.valid_rx && w_ready;
  assign w_fifo_we   = w_xfer && (r_state == WAIT_R) && (rx.id_rx == ID_RIGHT);
  assign sync_err    = r_sync_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WAIT_L;
      r_left     <= '0;
      r_sync_err <= '0;
    end else if (w_xfer) begin
      case (r_state)
        WAIT_L: begin
          if (rx.id_rx == ID_LEFT) begin
            r_left  <= w_sample;
            r_state <= WAIT_R;
          end else begin
            r_sync_err <= sat_inc8(r_sync_err);
          end
        end
        WAIT_R: begin
          if (rx.id_rx == ID_RIGHT) begin
            r_state <= WAIT_L;
          end else begin
            r_left     <= w_sample;
            r_sync_err <= sat_inc8(r_sync_err);
          end
        end
        default: r_state <= WAIT_L;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (2*AUDIO_WIDTH),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .we    (w_fifo_we),
    .din   ({r_left, w_sample}),
    .re    (rd_en),
    .dout  (data_out),
    .empty (empty),
    .full  (w_full),
    .level (level)
  );

endmodule

// File: tb/tb_live_audio_rx.sv
// Randomised and directed checks of live_audio_rx against a queue-based pairing model.
module tb_live_audio_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  live_audio_rx_if rx_pcm ();
  live_audio_rx_if rx_aes ();

  logic [31:0] pcm_data_out, aes_data_out;
  logic        pcm_rd_en, aes_rd_en;
  logic        pcm_empty, aes_empty;
  logic [4:0]  pcm_level, aes_level;
  logic [7:0]  pcm_sync_err, aes_sync_err;

  live_audio_rx #(.AUDIO_WIDTH(16), .BUFFER_DEPTH(4), .AES_MODE(0)) dut_pcm (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx_pcm),
    .data_out (pcm_data_out),
    .rd_en    (pcm_rd_en),
    .empty    (pcm_empty),
    .level    (pcm_level),
    .sync_err (pcm_sync_err)
  );

  live_audio_rx #(.AUDIO_WIDTH(16), .BUFFER_DEPTH(4), .AES_MODE(1)) dut_aes (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx_aes),
    .data_out (aes_data_out),
    .rd_en    (aes_rd_en),
    .empty    (aes_empty),
    .level    (aes_level),
    .sync_err (aes_sync_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a pending left sample, a queue of stereo words and an error tally.
  bit          m_have_left;
  logic [15:0] m_left;
  int          m_err;
  logic [31:0] m_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pcm_sample(input logic [31:0] d);
    return 16'(d / 32'h1_0000);
  endfunction

  function automatic bit model_ready();
    return !m_have_left || (m_q.size() < 16);
  endfunction

  task automatic check_outputs();
    check("empty", pcm_empty, m_q.size() == 0);
    check("level", pcm_level, m_q.size());
    check("ready_rx", rx_pcm.ready_rx, model_ready());
    check("sync_err", pcm_sync_err, m_err);
    if (m_q.size() > 0) check("data_out", pcm_data_out, m_q[0]);
  endtask

  // One cycle: drive at the falling edge, update the model at the rising edge, compare at the next fall.
  task automatic step(input bit v, input bit id, input logic [31:0] d, input bit re);
    bit xfer;
    rx_pcm.valid_rx = v;
    rx_pcm.id_rx    = id;
    rx_pcm.data_rx  = d;
    pcm_rd_en       = re;
    xfer = v && model_ready();
    @(posedge clk);
    if (re && m_q.size() > 0) void'(m_q.pop_front());
    if (xfer) begin
      if (id == 1'b0) begin
        if (m_have_left) m_err = (m_err < 255) ? m_err + 1 : 255;
        m_left      = pcm_sample(d);
        m_have_left = 1'b1;
      end else if (m_have_left) begin
        m_q.push_back({m_left, pcm_sample(d)});
        m_have_left = 1'b0;
      end else begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    rx_pcm.valid_rx = 1'b0;
    pcm_rd_en       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    m_have_left = 1'b0;
    m_left      = '0;
    m_err       = 0;
    m_q.delete();
    check_outputs();
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input bit re);
    step(1'b1, 1'b0, l, re);
    step(1'b1, 1'b1, r, re);
  endtask

  initial begin
    rx_pcm.valid_rx = 1'b0;
    rx_pcm.id_rx    = 1'b0;
    rx_pcm.data_rx  = '0;
    rx_aes.valid_rx = 1'b0;
    rx_aes.id_rx    = 1'b0;
    rx_aes.data_rx  = '0;
    pcm_rd_en       = 1'b0;
    aes_rd_en       = 1'b0;
    @(negedge clk);
    do_reset();
    check("aes_reset_empty", aes_empty, 1'b1);
    check("aes_reset_ready", rx_aes.ready_rx, 1'b1);

    // AES3 framing: sample sits in bits [27:12].
    rx_aes.valid_rx = 1'b1;
    rx_aes.id_rx    = 1'b0;
    rx_aes.data_rx  = 32'h0123_4560;
    @(posedge clk);
    @(negedge clk);
    rx_aes.id_rx    = 1'b1;
    rx_aes.data_rx  = 32'h0FED_CBA0;
    @(posedge clk);
    @(negedge clk);
    rx_aes.valid_rx = 1'b0;
    check("aes_data_out", aes_data_out, 32'h1234_FEDC);
    check("aes_empty", aes_empty, 1'b0);
    check("aes_level", aes_level, 5'd1);

    // Basic PCM pair.
    send_pair(32'h1234_0000, 32'hABCD_0000, 1'b0);
    check("pcm_pair_data", pcm_data_out, 32'h1234_ABCD);
    check("pcm_pair_level", pcm_level, 5'd1);

    // Fill to capacity with the 17th right subframe held off.
    do_reset();
    for (int i = 0; i < 16; i++) send_pair($urandom, $urandom, 1'b0);
    check("fill_level16", pcm_level, 5'd16);
    step(1'b1, 1'b0, 32'h5555_0000, 1'b0);
    step(1'b1, 1'b1, 32'h6666_0000, 1'b0);
    check("fill_ready_held", rx_pcm.ready_rx, 1'b0);
    step(1'b1, 1'b1, 32'h6666_0000, 1'b0);
    step(1'b1, 1'b1, 32'h6666_0000, 1'b1);
    check("fill_ready_after_pop", rx_pcm.ready_rx, 1'b1);
    step(1'b1, 1'b1, 32'h6666_0000, 1'b0);
    check("fill_level_after", pcm_level, 5'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, 1'b1);
    check("fill_last_drained", pcm_empty, 1'b1);

    // Out-of-order sequence R, L, L, R.
    do_reset();
    step(1'b1, 1'b1, 32'h0009_0000, 1'b0);
    step(1'b1, 1'b0, 32'h0001_0000, 1'b0);
    step(1'b1, 1'b0, 32'h0002_0000, 1'b0);
    step(1'b1, 1'b1, 32'h0003_0000, 1'b0);
    check("ooo_sync_err", pcm_sync_err, 8'd2);
    check("ooo_word", pcm_data_out, 32'h0002_0003);
    check("ooo_level", pcm_level, 5'd1);

    // Reset in WAIT_R with words stored.
    do_reset();
    for (int i = 0; i < 5; i++) send_pair($urandom, $urandom, 1'b0);
    step(1'b1, 1'b0, $urandom, 1'b0);
    check("midpair_level5", pcm_level, 5'd5);
    do_reset();
    check("midpair_empty", pcm_empty, 1'b1);
    check("midpair_level0", pcm_level, 5'd0);
    check("midpair_ready", rx_pcm.ready_rx, 1'b1);
    step(1'b1, 1'b1, $urandom, 1'b0);
    check("midpair_lone_right", pcm_sync_err, 8'd1);
    check("midpair_still_empty", pcm_empty, 1'b1);

    // Streaming at rate with the reader always popping.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      send_pair($urandom, $urandom, 1'b1);
      check("stream_level_le1", pcm_level <= 5'd1, 1'b1);
    end

    // Random traffic; plenty of misordered ids drive sync_err into saturation.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom_range(0, 2) == 0);
    check("sat_sync_err", pcm_sync_err, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
